// File: rtl/simon_pkg.sv
// Shared definitions for the Puvvada Says game: color codes, debounce FSM
// state encoding and the default debounce length.
package simon_pkg;

    localparam int NUM_BTNS                = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

    // Color codes shared with the game FSM (gColor) and the VGA color map.
    localparam logic [1:0] COLOR_U = 2'd0;
    localparam logic [1:0] COLOR_R = 2'd1;
    localparam logic [1:0] COLOR_D = 2'd2;
    localparam logic [1:0] COLOR_L = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_CNT = 2'd1,
        ST_HELD      = 2'd2,
        ST_REL_CNT   = 2'd3
    } btn_state_t;

    // Buttons are indexed U,R,D,L; a one-hot strobe vector maps to its color.
    function automatic logic [1:0] btn_color(input logic [NUM_BTNS-1:0] onehot);
        logic [1:0] color;
        color = COLOR_U;
        case (onehot)
            4'b0001: color = COLOR_U;
            4'b0010: color = COLOR_R;
            4'b0100: color = COLOR_D;
            4'b1000: color = COLOR_L;
            default: color = COLOR_U;
        endcase
        return color;
    endfunction

endpackage

// File: rtl/btn_debounce_fsm.sv
// Per-button conditioner: 2-flop synchronizer, debounce counter and the
// IDLE/PRESS_CNT/HELD/REL_CNT FSM. Raises a one-cycle qualify strobe on an
// accepted press and reports held while the debounced level is pressed.
module btn_debounce_fsm
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic qualify,
    output logic held
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          level;
    btn_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          qualify_nxt;

    assign level = sync[1];
    assign held  = (state == ST_HELD) || (state == ST_REL_CNT);

    // Synchronizer resets to "pressed" so a button held through reset is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], raw};
    end

    // State, counter and strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_REL_CNT;
            cnt     <= '0;
            qualify <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            qualify <= qualify_nxt;
        end
    end

    // Debounce transitions: a level change must persist until the counter
    // reaches its last value before the debounced state flips.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        qualify_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (level) begin
                    state_nxt = ST_PRESS_CNT;
                    cnt_nxt   = '0;
                end
            end
            ST_PRESS_CNT: begin
                if (!level) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = ST_HELD;
                    qualify_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_HELD: begin
                if (!level) begin
                    state_nxt = ST_REL_CNT;
                    cnt_nxt   = '0;
                end
            end
            ST_REL_CNT: begin
                if (level) begin
                    state_nxt = ST_HELD;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = ST_REL_CNT;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/simon_btn_conditioner.sv
// Button input stage: four debounced buttons, single-press arbitration,
// color encoding and registered event outputs for the game FSM.
module simon_btn_conditioner
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Btn_U,
    input  logic       Btn_R,
    input  logic       Btn_D,
    input  logic       Btn_L,
    input  logic       Enable,
    output logic       btn_valid,
    output logic [1:0] btn_code,
    output logic       multi_press,
    output logic       any_held
);

    logic [NUM_BTNS-1:0] raw;
    logic [NUM_BTNS-1:0] qualify;
    logic [NUM_BTNS-1:0] held;
    logic                single;
    logic                clash;
    logic [1:0]          code_nxt;

    // Bit order matches the color codes: U=0, R=1, D=2, L=3.
    assign raw = {Btn_L, Btn_D, Btn_R, Btn_U};

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debounce_fsm #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_fsm (
            .clk     (Clk),
            .rst_n   (Reset_n),
            .raw     (raw[i]),
            .qualify (qualify[i]),
            .held    (held[i])
        );
    end

    // Arbitration: a strobe is clean only if it is alone and no other button
    // is still debounced-pressed; anything else is an overlap.
    always_comb begin
        clash = 1'b0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            if (qualify[i] && |(held & ~(NUM_BTNS'(1) << i))) clash = 1'b1;
        end
        if ($countones(qualify) > 1) clash = 1'b1;
        single   = ($countones(qualify) == 1) && !clash;
        code_nxt = btn_color(qualify);
    end

    // Output registers; Enable only gates clean presses, never overlap flags.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            btn_valid   <= 1'b0;
            multi_press <= 1'b0;
            btn_code    <= COLOR_U;
            any_held    <= 1'b1;
        end else begin
            btn_valid   <= single && Enable;
            multi_press <= clash;
            any_held    <= |held;
            if (single && Enable) btn_code <= code_nxt;
        end
    end

endmodule

// File: tb/tb_simon_btn_conditioner.sv
// Scoreboard bench: a run-length reference model predicts events into a
// queue; a monitor pops and compares whenever the DUT pulses an output.
module tb_simon_btn_conditioner;

    localparam int D = 4;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Btn_U = 1'b0, Btn_R = 1'b0, Btn_D = 1'b0, Btn_L = 1'b0;
    logic       Enable = 1'b0;
    logic       btn_valid;
    logic [1:0] btn_code;
    logic       multi_press;
    logic       any_held;

    simon_btn_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Btn_U       (Btn_U),
        .Btn_R       (Btn_R),
        .Btn_D       (Btn_D),
        .Btn_L       (Btn_L),
        .Enable      (Enable),
        .btn_valid   (btn_valid),
        .btn_code    (btn_code),
        .multi_press (multi_press),
        .any_held    (any_held)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int         cyc;
        bit         multi;
        logic [1:0] code;
    } ev_t;

    ev_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_valid  = 0;
    int n_multi  = 0;
    int last_valid_cyc = -1;

    // Reference model state: sampled-level pipeline, debounced mode per
    // button, run length of samples disagreeing with the mode.
    logic [3:0] sh0 = 4'hF, sh1 = 4'hF, mode = 4'hF;
    int         run[4] = '{0, 0, 0, 0};
    logic       exp_any = 1'b1;
    logic [1:0] exp_code = 2'd0;
    int         pend_n = 0;
    bit         pend_other = 1'b0;
    logic [1:0] pend_code = 2'd0;

    function automatic void check(string name, int got, int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, want);
        end
    endfunction

    // Reference model: a button's debounced mode flips once the synchronized
    // level has disagreed with it for D+1 consecutive samples. Accepted
    // presses are arbitrated one cycle later with the Enable seen then.
    initial begin
        logic [3:0] lvl;
        logic [3:0] strobes;
        forever begin
            @(posedge Clk or negedge Reset_n);
            cyc++;
            if (!Reset_n) begin
                sh0 = 4'hF; sh1 = 4'hF; mode = 4'hF;
                for (int i = 0; i < 4; i++) run[i] = 0;
                exp_any = 1'b1; exp_code = 2'd0;
                pend_n = 0; pend_other = 1'b0;
                exp_q.delete();
            end else begin
                if (pend_n > 0) begin
                    if (pend_n > 1 || pend_other) begin
                        exp_q.push_back('{cyc, 1'b1, exp_code});
                    end else if (Enable) begin
                        exp_code = pend_code;
                        exp_q.push_back('{cyc, 1'b0, pend_code});
                    end
                end
                exp_any = |mode;
                lvl = sh1;
                sh1 = sh0;
                sh0 = {Btn_L, Btn_D, Btn_R, Btn_U};
                strobes = 4'b0;
                for (int i = 0; i < 4; i++) begin
                    if (lvl[i] != mode[i]) begin
                        run[i]++;
                        if (run[i] == D + 1) begin
                            mode[i] = lvl[i];
                            run[i]  = 0;
                            if (lvl[i]) strobes[i] = 1'b1;
                        end
                    end else begin
                        run[i] = 0;
                    end
                end
                pend_n = $countones(strobes);
                pend_other = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (strobes[i]) begin
                        pend_code = 2'(i);
                        if (|(mode & ~(4'b0001 << i))) pend_other = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: compares level outputs every cycle and pops one expected event
    // per DUT pulse; overdue events count as misses.
    initial begin
        ev_t e;
        forever begin
            @(negedge Clk);
            if (Reset_n) begin
                check("any_held", int'(any_held), int'(exp_any));
                check("btn_code_level", int'(btn_code), int'(exp_code));
                if (btn_valid && multi_press) begin
                    n_checks++; n_fail++;
                    $display("FAIL valid_and_multi at cycle %0d: both outputs high", cyc);
                end
                if (btn_valid || multi_press) begin
                    if (btn_valid) begin n_valid++; last_valid_cyc = cyc; end
                    if (multi_press) n_multi++;
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_event at cycle %0d: valid=%0d multi=%0d code=%0d, none expected",
                                 cyc, btn_valid, multi_press, btn_code);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_cycle", cyc, e.cyc);
                        check("event_multi", int'(multi_press), int'(e.multi));
                        check("event_code", int'(btn_code), int'(e.code));
                    end
                end
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    n_checks++; n_fail++;
                    $display("FAIL missed_event: expected multi=%0d code=%0d at cycle %0d, nothing seen",
                             exp_q[0].multi, exp_q[0].code, exp_q[0].cyc);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic pulse_reset();
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("rst_btn_valid", int'(btn_valid), 0);
        check("rst_multi_press", int'(multi_press), 0);
        check("rst_btn_code", int'(btn_code), 0);
        check("rst_any_held", int'(any_held), 1);
        @(negedge Clk);
        #2 Reset_n = 1'b1;
    endtask

    task automatic set_btns(input logic [3:0] b);
        {Btn_L, Btn_D, Btn_R, Btn_U} = b;
    endtask

    initial begin
        int v0, m0, c0;
        int dur[4];
        logic [3:0] b;

        // Reset, release with buttons low; releases confirm after D+3 edges.
        pulse_reset();
        wait_cycles(12);
        check("idle_any_held", int'(any_held), 0);

        // Short glitch on U: no event, any_held stays low.
        v0 = n_valid; m0 = n_multi;
        @(negedge Clk); set_btns(4'b0001);
        wait_cycles(3);
        set_btns(4'b0000);
        wait_cycles(12);
        check("glitch_no_valid", n_valid, v0);
        check("glitch_no_multi", n_multi, m0);

        // Clean R press: valid in the cycle after edge D+3, one pulse only.
        Enable = 1'b1;
        v0 = n_valid;
        @(negedge Clk); set_btns(4'b0010); c0 = cyc;
        wait_cycles(20);
        check("r_single_pulse", n_valid, v0 + 1);
        check("r_latency", last_valid_cyc, c0 + 8);
        check("r_code", int'(btn_code), 1);
        set_btns(4'b0000);
        wait_cycles(12);

        // D and L together: one overlap flag, code keeps R.
        v0 = n_valid; m0 = n_multi;
        @(negedge Clk); set_btns(4'b1100);
        wait_cycles(15);
        check("dl_multi", n_multi, m0 + 1);
        check("dl_no_valid", n_valid, v0);
        check("dl_code_kept", int'(btn_code), 1);
        set_btns(4'b0000);
        wait_cycles(12);

        // U held, L joins 10 cycles later: U accepted, L flagged.
        v0 = n_valid; m0 = n_multi;
        @(negedge Clk); set_btns(4'b0001);
        wait_cycles(10);
        set_btns(4'b1001);
        wait_cycles(15);
        check("ul_valid", n_valid, v0 + 1);
        check("ul_multi", n_multi, m0 + 1);
        check("ul_code", int'(btn_code), 0);
        set_btns(4'b0000);
        wait_cycles(12);

        // Enable low swallows D; later D with Enable high is reported.
        Enable = 1'b0;
        v0 = n_valid; m0 = n_multi;
        @(negedge Clk); set_btns(4'b0100);
        wait_cycles(15);
        check("d_disabled_valid", n_valid, v0);
        check("d_disabled_multi", n_multi, m0);
        set_btns(4'b0000);
        wait_cycles(12);
        Enable = 1'b1;
        @(negedge Clk); set_btns(4'b0100);
        wait_cycles(15);
        check("d_enabled_valid", n_valid, v0 + 1);
        check("d_enabled_code", int'(btn_code), 2);
        set_btns(4'b0000);
        wait_cycles(12);

        // R held across a reset: ignored until released and pressed again.
        v0 = n_valid;
        @(negedge Clk); set_btns(4'b0010);
        wait_cycles(4);
        pulse_reset();
        wait_cycles(20);
        check("rst_hold_no_valid", n_valid, v0);
        check("rst_hold_code", int'(btn_code), 0);
        set_btns(4'b0000);
        wait_cycles(8);
        set_btns(4'b0010);
        wait_cycles(15);
        check("rst_repress_valid", n_valid, v0 + 1);
        check("rst_repress_code", int'(btn_code), 1);
        set_btns(4'b0000);
        wait_cycles(12);

        // Random bouncing buttons, Enable changes and one mid-run reset.
        for (int i = 0; i < 4; i++) dur[i] = $urandom_range(1, 20);
        b = 4'b0000;
        for (int t = 0; t < 3000; t++) begin
            if (t == 1500) pulse_reset();
            @(negedge Clk);
            for (int i = 0; i < 4; i++) begin
                dur[i]--;
                if (dur[i] <= 0) begin
                    b[i] = ~b[i];
                    dur[i] = b[i] ? $urandom_range(1, 14) : $urandom_range(1, 30);
                end
            end
            set_btns(b);
            if ($urandom_range(0, 19) == 0) Enable = ~Enable;
        end
        set_btns(4'b0000);
        wait_cycles(30);
        check("queue_drained", exp_q.size(), 0);
        check("final_any_held", int'(any_held), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
